melody_sequencer: RTL

//   Plays game sound-effect tunes (shot, hit, invader step, game over) by stepping a note ROM and

---
 rtl/melody_pkg.sv | 73 +++++++
 rtl/melody_rom.sv | 16 +
 rtl/melody_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: ROM entry layout, note codes,
// tune start addresses, FSM states and the note ROM image.
package melody_pkg;

    localparam int ENTRY_W     = 12;
    localparam int REST_BIT    = 11;
    localparam int LAST_BIT    = 10;
    localparam int NOTE_MSB    = 9;
    localparam int NOTE_LSB    = 6;
    localparam int DUR_MSB     = 5;
    localparam int DUR_LSB     = 0;
    localparam int NUM_TUNES   = 4;
    localparam int TUNE_ADDR_W = 6;

    typedef enum logic [3:0] {
        NOTE_C   = 4'd0,
        NOTE_D   = 4'd1,
        NOTE_E   = 4'd2,
        NOTE_F   = 4'd3,
        NOTE_G   = 4'd4,
        NOTE_A   = 4'd5,
        NOTE_B   = 4'd6,
        NOTE_HC  = 4'd7,
        NOTE_HD  = 4'd8,
        NOTE_HE  = 4'd9,
        NOTE_HF  = 4'd10,
        NOTE_HG  = 4'd11,
        NOTE_HA  = 4'd12,
        NOTE_HB  = 4'd13,
        NOTE_HHC = 4'd14
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_PLAY  = 2'd3
    } state_t;

    // Index 0 is the rightmost element: shot, hit, invader step, game over.
    localparam logic [NUM_TUNES-1:0][TUNE_ADDR_W-1:0] TUNE_BASE =
        {6'd56, 6'd8, 6'd4, 6'd0};

    function automatic logic [ENTRY_W-1:0] entry(input logic rest, input logic last,
                                                 input note_t note, input logic [5:0] dur);
        return {rest, last, note, dur};
    endfunction

    // Game-over tune (56..63) has no last flag and relies on the end-of-ROM stop.
    function automatic logic [ENTRY_W-1:0] rom_word(input int unsigned a);
        logic [ENTRY_W-1:0] w;
        case (a)
            0:       w = entry(1'b0, 1'b0, NOTE_HC,  6'd1);
            1:       w = entry(1'b0, 1'b1, NOTE_G,   6'd1);
            4:       w = entry(1'b0, 1'b0, NOTE_C,   6'd2);
            5:       w = entry(1'b0, 1'b1, NOTE_E,   6'd1);
            8:       w = entry(1'b1, 1'b0, NOTE_D,   6'd3);
            9:       w = entry(1'b0, 1'b0, NOTE_G,   6'd1);
            10:      w = entry(1'b0, 1'b1, NOTE_E,   6'd1);
            56:      w = entry(1'b0, 1'b0, NOTE_B,   6'd1);
            57:      w = entry(1'b0, 1'b0, NOTE_HC,  6'd0);
            58:      w = entry(1'b0, 1'b0, NOTE_A,   6'd1);
            59:      w = entry(1'b0, 1'b0, NOTE_G,   6'd1);
            60:      w = entry(1'b0, 1'b0, NOTE_F,   6'd1);
            61:      w = entry(1'b0, 1'b0, NOTE_E,   6'd1);
            62:      w = entry(1'b0, 1'b0, NOTE_D,   6'd1);
            63:      w = entry(1'b0, 1'b0, NOTE_HHC, 6'd1);
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Synchronous-read note ROM; data appears the cycle after addr is presented.
module melody_rom
    import melody_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic               clk,
    input  logic [ADDR_W-1:0]  addr,
    output logic [ENTRY_W-1:0] data
);

    always_ff @(posedge clk) begin
        data <= rom_word(32'(addr));
    end

endmodule

// File: rtl/melody_sequencer.sv
// Steps the note ROM for a selected tune and drives timed note_sel/sound_en to the buzzer.
//   state | meaning
//   IDLE  | no tune, outputs quiet
//   FETCH | ROM address presented
//   LOAD  | ROM entry latched, note length computed
//   PLAY  | note sounding (or resting), duration counter running down
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int UNIT_CYC = 120_000,
    parameter int GAP_CYC  = 12_000,
    parameter int ADDR_W   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] tune_sel,
    input  logic       stop,
    output logic [3:0] note_sel,
    output logic       sound_en,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2(63 * UNIT_CYC + 1);
    localparam logic [ADDR_W-1:0] ADDR_END = '1;

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [1:0]         cur_tune;
    logic [CNT_W-1:0]   cnt;
    logic               rest_q;
    logic               last_q;
    logic [ENTRY_W-1:0] rom_data;
    logic [5:0]         dur_eff;
    logic [CNT_W-1:0]   play_len;
    logic               accept;

    melody_rom #(.ADDR_W(ADDR_W)) u_rom (
        .clk  (clk),
        .addr (addr),
        .data (rom_data)
    );

    always_comb begin
        dur_eff = rom_data[DUR_MSB:DUR_LSB];
        if (dur_eff == 6'd0) begin
            dur_eff = 6'd1;
        end
        play_len = CNT_W'(dur_eff) * CNT_W'(UNIT_CYC);
    end

    // A new request wins from idle, or pre-empts a lower-priority (higher index) tune.
    assign accept = start && ((state == ST_IDLE) || (tune_sel < cur_tune));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            addr     <= '0;
            cur_tune <= '0;
            cnt      <= '0;
            rest_q   <= 1'b0;
            last_q   <= 1'b0;
            note_sel <= '0;
            sound_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= ST_IDLE;
                sound_en <= 1'b0;
                busy     <= 1'b0;
            end else if (accept) begin
                state    <= ST_FETCH;
                addr     <= ADDR_W'(TUNE_BASE[tune_sel]);
                cur_tune <= tune_sel;
                sound_en <= 1'b0;
                busy     <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_FETCH: begin
                        state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        state    <= ST_PLAY;
                        note_sel <= rom_data[NOTE_MSB:NOTE_LSB];
                        rest_q   <= rom_data[REST_BIT];
                        last_q   <= rom_data[LAST_BIT];
                        cnt      <= play_len - CNT_W'(1);
                        sound_en <= ~rom_data[REST_BIT];
                    end
                    ST_PLAY: begin
                        if (cnt == '0) begin
                            sound_en <= 1'b0;
                            if (last_q || (addr == ADDR_END)) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                addr  <= addr + ADDR_W'(1);
                                state <= ST_FETCH;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                            // Final GAP_CYC cycles of each note are silent for articulation.
                            sound_en <= ~rest_q && (cnt > CNT_W'(GAP_CYC));
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
